pending_request_encoder: RTL and testbench

//  Latches single-cycle request pulses into a pending register. Presents the

---
 rtl/pending_request_encoder.sv | 109 ++++++++++
 tb/tb_pending_request_encoder.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/pending_request_encoder.sv
// pending_request_encoder
//   Latches single-cycle request pulses into a pending register and hands out
//   the highest pending index (MSB = highest priority) through a registered
//   valid/ready output stage, one index per accepted transfer.
//   Optional feature macro: PENDING_OVERFLOW_EN adds sticky per-line overflow
//   flags (overflow) and their clear input (overflow_clear).
module pending_request_encoder #(
   parameter int unsigned NUM_INPUTS = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_INPUTS-1:0]         req,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [$clog2(NUM_INPUTS)-1:0] out_index,
   output logic [NUM_INPUTS-1:0]         pending,
`ifdef PENDING_OVERFLOW_EN
   input  logic                          overflow_clear,
   output logic [NUM_INPUTS-1:0]         overflow,
`endif
   output logic                          busy
);

   localparam int unsigned NUM_OUTPUTS = $clog2(NUM_INPUTS);

   logic [NUM_INPUTS-1:0]  r_pending;
   logic                   r_out_valid;
   logic [NUM_OUTPUTS-1:0] r_out_index;

   logic                   w_load;
   logic                   w_any;
   logic [NUM_OUTPUTS-1:0] w_top_idx;
   logic [NUM_INPUTS-1:0]  w_claim;
   logic [NUM_INPUTS-1:0]  w_pending_d;

   // Output stage may take a new index when empty or when being drained.
   assign w_load = ~r_out_valid | out_ready;
   assign w_any  = |r_pending;

   // Priority encode the registered pending bits; the ascending scan lets the
   // highest set bit win.
   always_comb begin
      w_top_idx = '0;
      for (int i = 0; i < int'(NUM_INPUTS); i++) begin
         if (r_pending[i]) begin
            w_top_idx = NUM_OUTPUTS'(i);
         end
      end
   end

   // Claim the encoded bit when it moves into the output stage; a new request
   // on the same line re-sets it so the index is delivered again.
   always_comb begin
      w_claim = '0;
      for (int i = 0; i < int'(NUM_INPUTS); i++) begin
         if (w_load && w_any && (w_top_idx == NUM_OUTPUTS'(i))) begin
            w_claim[i] = 1'b1;
         end
      end
      w_pending_d = (r_pending & ~w_claim) | req;
   end

   // Pending register and registered output stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pending   <= '0;
         r_out_valid <= 1'b0;
         r_out_index <= '0;
      end else begin
         r_pending <= w_pending_d;
         if (w_load) begin
            if (w_any) begin
               r_out_valid <= 1'b1;
               r_out_index <= w_top_idx;
            end else begin
               r_out_valid <= 1'b0;
            end
         end
      end
   end

`ifdef PENDING_OVERFLOW_EN
   logic [NUM_INPUTS-1:0] r_overflow;
   logic [NUM_INPUTS-1:0] w_overflow_set;

   // A request arriving on a line already pending merges and is lost; the
   // output stage holding that index does not count as pending.
   assign w_overflow_set = req & r_pending;

   // Sticky overflow flags; a same-cycle set beats the clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_overflow <= '0;
      end else if (overflow_clear) begin
         r_overflow <= w_overflow_set;
      end else begin
         r_overflow <= r_overflow | w_overflow_set;
      end
   end

   assign overflow = r_overflow;
`endif

   assign out_valid = r_out_valid;
   assign out_index = r_out_index;
   assign pending   = r_pending;
   assign busy      = w_any | r_out_valid;

endmodule

// File: tb/tb_pending_request_encoder.sv
// tb_pending_request_encoder
//   Table-driven scoreboard run for the drain sequence plus hand-written
//   sequences for stall, re-request, mid-operation reset and (when
//   PENDING_OVERFLOW_EN is defined) overflow flag behaviour.
module tb_pending_request_encoder;

   localparam int unsigned N = 16;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [N-1:0] req = '0;
   logic         out_ready = 1'b1;
   logic         out_valid;
   logic [3:0]   out_index;
   logic [N-1:0] pending;
   logic         busy;
`ifdef PENDING_OVERFLOW_EN
   logic         overflow_clear = 1'b0;
   logic [N-1:0] overflow;
`endif

   pending_request_encoder #(.NUM_INPUTS(N)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .req            (req),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_index      (out_index),
      .pending        (pending),
`ifdef PENDING_OVERFLOW_EN
      .overflow_clear (overflow_clear),
      .overflow       (overflow),
`endif
      .busy           (busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic [N-1:0] req;
      int           exp_count;
      int           exp_first;
   } vec_t;

   vec_t vecs[6];
   int   sb_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Advance one clock; sample/drive 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int first_cyc;
      int got;
      int exp_idx;
      int first_idx;
      int seen_valid;

      vecs[0] = '{req: 16'h0001, exp_count: 1,  exp_first: 0};
      vecs[1] = '{req: 16'h8421, exp_count: 4,  exp_first: 15};
      vecs[2] = '{req: 16'hFFFF, exp_count: 16, exp_first: 15};
      vecs[3] = '{req: 16'h0100, exp_count: 1,  exp_first: 8};
      vecs[4] = '{req: 16'h8000, exp_count: 1,  exp_first: 15};
      vecs[5] = '{req: 16'h0006, exp_count: 2,  exp_first: 2};

      // Reset state
      #1;
      check("reset_valid", 32'(out_valid), 32'd0);
      check("reset_pending", 32'(pending), 32'd0);
      check("reset_index", 32'(out_index), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
`ifdef PENDING_OVERFLOW_EN
      check("reset_overflow", 32'(overflow), 32'd0);
`endif
      #11 rst_n = 1'b1;
      step();

      // Scoreboard drain with out_ready held high
      out_ready = 1'b1;
      foreach (vecs[v]) begin
         req = vecs[v].req;
         for (int i = N - 1; i >= 0; i--) begin
            if (vecs[v].req[i]) sb_q.push_back(i);
         end
         step();
         req = '0;
         check($sformatf("v%0d_pending_c1", v), 32'(pending), 32'(vecs[v].req));
         first_cyc = -1;
         first_idx = -1;
         got = 0;
         for (int c = 2; c <= 40 && (sb_q.size() > 0 || busy); c++) begin
            step();
            if (out_valid) begin
               if (first_cyc < 0) begin
                  first_cyc = c;
                  first_idx = int'(out_index);
               end
               got++;
               if (sb_q.size() == 0) begin
                  check($sformatf("v%0d_extra_output", v), 32'(out_index), 32'hFFFF_FFFF);
               end else begin
                  exp_idx = sb_q.pop_front();
                  check($sformatf("v%0d_index", v), 32'(out_index), 32'(exp_idx));
               end
            end
         end
         check($sformatf("v%0d_sb_left", v), 32'(sb_q.size()), 32'd0);
         sb_q.delete();
         check($sformatf("v%0d_latency", v), 32'(first_cyc), 32'd2);
         check($sformatf("v%0d_first", v), 32'(first_idx), 32'(vecs[v].exp_first));
         check($sformatf("v%0d_count", v), 32'(got), 32'(vecs[v].exp_count));
         check($sformatf("v%0d_busy_end", v), 32'(busy), 32'd0);
         check($sformatf("v%0d_pending_end", v), 32'(pending), 32'd0);
         step();
      end

      // Stalled output is not preempted by a higher-priority arrival
      out_ready = 1'b0;
      req = 16'h0008;
      step();
      req = '0;
      step();
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_index3", 32'(out_index), 32'd3);
      req = 16'h1000;
      step();
      req = '0;
      step();
      check("stall_hold_index", 32'(out_index), 32'd3);
      check("stall_hold_valid", 32'(out_valid), 32'd1);
      check("stall_pending12", 32'(pending), 32'h1000);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("stall_next_index", 32'(out_index), 32'd12);
      check("stall_next_valid", 32'(out_valid), 32'd1);
      step();
      check("stall_hold12", 32'(out_index), 32'd12);
      check("stall_pending_clr", 32'(pending), 32'd0);
      out_ready = 1'b1;
      step();
      check("stall_empty", 32'(out_valid), 32'd0);

      // Re-request of the in-flight index is delivered again
      out_ready = 1'b0;
      req = 16'h0080;
      step();
      req = '0;
      step();
      check("rereq_index7", 32'(out_index), 32'd7);
      req = 16'h0080;
      step();
      req = '0;
      check("rereq_pending", 32'(pending), 32'h0080);
      check("rereq_hold", 32'(out_index), 32'd7);
      out_ready = 1'b1;
      step();
      check("rereq_again_valid", 32'(out_valid), 32'd1);
      check("rereq_again_index", 32'(out_index), 32'd7);
      check("rereq_pending_clr", 32'(pending), 32'd0);
      step();
      check("rereq_done", 32'(out_valid), 32'd0);

      // Asynchronous reset mid-drain discards everything
      req = 16'hFFFF;
      step();
      req = '0;
      step();
      step();
      step();
      check("rst_pre_index", 32'(out_index), 32'd13);
      #2 rst_n = 1'b0;
      #1;
      check("rst_async_valid", 32'(out_valid), 32'd0);
      check("rst_async_pending", 32'(pending), 32'd0);
      check("rst_async_index", 32'(out_index), 32'd0);
      check("rst_async_busy", 32'(busy), 32'd0);
      #5 rst_n = 1'b1;
      seen_valid = 0;
      for (int c = 0; c < 5; c++) begin
         step();
         if (out_valid || pending != '0) seen_valid++;
      end
      check("rst_no_replay", 32'(seen_valid), 32'd0);

`ifdef PENDING_OVERFLOW_EN
      // Overflow flags: set on merge, set beats clear, clear alone empties
      check("ovf_after_reset", 32'(overflow), 32'd0);
      out_ready = 1'b0;
      req = 16'h0010;
      step();
      step();
      req = '0;
      check("ovf_set", 32'(overflow), 32'h0010);
      overflow_clear = 1'b1;
      req = 16'h0010;
      step();
      req = '0;
      check("ovf_set_beats_clear", 32'(overflow), 32'h0010);
      step();
      overflow_clear = 1'b0;
      check("ovf_cleared", 32'(overflow), 32'd0);
      out_ready = 1'b1;
      step();
      step();
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
